// File: rtl/hamming_encoder_8_4_stream.sv
// hamming_encoder_8_4_stream
//   Streaming extended Hamming(8,4) SECDED encoder. Each accepted byte is
//   split into two nibbles, and each nibble is emitted as one 8-bit codeword
//   on a registered valid/ready output. A per-byte XOR mask can flip codeword
//   bits so that the downstream decoder's correct and detect paths get exercised.
//
// Parameters
//   LOW_NIBBLE_FIRST  1: in_data[3:0] is encoded first; 0: in_data[7:4] first
//   CNT_W             width of the transferred-codeword counter
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_data    data byte
//   in_valid   in_data / inj_mask valid
//   in_ready   byte accepted on in_valid & in_ready
//   inj_mask   XOR mask applied to both codewords of the byte
//   out_code   codeword: bit0 overall parity, bits 1/2/4 parity, bits 3/5/6/7 data
//   out_valid  out_code valid
//   out_ready  codeword transferred on out_valid & out_ready
//   cw_count   number of transferred codewords (wraps)
module hamming_encoder_8_4_stream #(
  parameter bit LOW_NIBBLE_FIRST = 1'b1,
  parameter int CNT_W            = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       inj_mask,
  output logic [7:0]       out_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cw_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND0 = 2'd1,
    SEND1 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       mask_q, mask_d;
  logic [7:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Nibble -> extended Hamming codeword. Data sits at positions 3/5/6/7 so the
  // XOR of set-bit indices over c[7:1] is zero; c0 makes total parity even.
  function automatic logic [7:0] enc(input logic [3:0] n);
    logic [7:0] c;
    c[3] = n[0];
    c[5] = n[1];
    c[6] = n[2];
    c[7] = n[3];
    c[1] = n[0] ^ n[1] ^ n[3];
    c[2] = n[0] ^ n[2] ^ n[3];
    c[4] = n[1] ^ n[2] ^ n[3];
    c[0] = ^c[7:1];
    return c;
  endfunction

  function automatic logic [3:0] first_nib(input logic [7:0] b);
    return LOW_NIBBLE_FIRST ? b[3:0] : b[7:4];
  endfunction

  function automatic logic [3:0] second_nib(input logic [7:0] b);
    return LOW_NIBBLE_FIRST ? b[7:4] : b[3:0];
  endfunction

  // A new byte can be taken while the last codeword of the previous byte is
  // leaving, giving bubble-free streaming; hence the out_ready -> in_ready path.
  assign in_ready = !rst && ((state_q == IDLE) || ((state_q == SEND1) && out_ready));

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mask_d  = mask_q;
    code_d  = code_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;

    if (valid_q && out_ready) begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          mask_d  = inj_mask;
          code_d  = enc(first_nib(in_data)) ^ inj_mask;
          valid_d = 1'b1;
          state_d = SEND0;
        end
      end
      SEND0: begin
        if (out_ready) begin
          code_d  = enc(second_nib(data_q)) ^ mask_q;
          state_d = SEND1;
        end
      end
      SEND1: begin
        if (out_ready) begin
          if (in_valid) begin
            data_d  = in_data;
            mask_d  = inj_mask;
            code_d  = enc(first_nib(in_data)) ^ inj_mask;
            state_d = SEND0;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= 8'h00;
      mask_q  <= 8'h00;
      code_q  <= 8'h00;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_code  = code_q;
  assign out_valid = valid_q;
  assign cw_count  = cnt_q;

endmodule

// File: tb/tb_hamming_encoder_8_4_stream.sv
// Directed testbench for hamming_encoder_8_4_stream. Two instances share the
// input stimulus: dut (low nibble first, 16-bit counter) and dut_hi (high
// nibble first, 4-bit counter so the counter wrap is reached quickly).
module tb_hamming_encoder_8_4_stream;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] inj_mask;
  logic [7:0] out_code;
  logic       out_valid;
  logic       out_ready;
  logic [15:0] cw_count;

  logic       hi_in_ready;
  logic [7:0] hi_out_code;
  logic       hi_out_valid;
  logic [3:0] hi_cw_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] tbl [16];

  hamming_encoder_8_4_stream #(.LOW_NIBBLE_FIRST(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .inj_mask(inj_mask), .out_code(out_code),
    .out_valid(out_valid), .out_ready(out_ready), .cw_count(cw_count)
  );

  hamming_encoder_8_4_stream #(.LOW_NIBBLE_FIRST(1'b0), .CNT_W(4)) dut_hi (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(hi_in_ready), .inj_mask(inj_mask), .out_code(hi_out_code),
    .out_valid(hi_out_valid), .out_ready(out_ready), .cw_count(hi_cw_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  // XOR of indices of set bits in c[7:1] combined with overall parity;
  // zero for every clean codeword.
  function automatic logic [3:0] syn_par(input logic [7:0] c);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 1; i < 8; i++) if (c[i]) s = s ^ 3'(i);
    return {s, ^c};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = 8'h00; tbl[1]  = 8'h0F; tbl[2]  = 8'h33; tbl[3]  = 8'h3C;
    tbl[4]  = 8'h55; tbl[5]  = 8'h5A; tbl[6]  = 8'h66; tbl[7]  = 8'h69;
    tbl[8]  = 8'h96; tbl[9]  = 8'h99; tbl[10] = 8'hA5; tbl[11] = 8'hAA;
    tbl[12] = 8'hC3; tbl[13] = 8'hCC; tbl[14] = 8'hF0; tbl[15] = 8'hFF;

    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; inj_mask = 8'h00; out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready", 16'(in_ready), 16'd0);
    chk("rst_valid", 16'(out_valid), 16'd0);
    chk("rst_code", 16'(out_code), 16'h00);
    chk("rst_count", cw_count, 16'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", 16'(in_ready), 16'd1);

    // Byte 0x81 single transfer; both nibble orders.
    in_data = 8'h81; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("a_cw0", 16'(out_code), 16'h0F);
    chk("a_hi_cw0", 16'(hi_out_code), 16'h96);
    chk("a_valid", 16'(out_valid), 16'd1);
    chk("a_rdy_send0", 16'(in_ready), 16'd0);
    step();
    chk("a_cw1", 16'(out_code), 16'h96);
    chk("a_hi_cw1", 16'(hi_out_code), 16'h0F);
    chk("a_rdy_send1", 16'(in_ready), 16'd1);
    chk("a_count1", cw_count, 16'd1);
    step();
    chk("a_idle_valid", 16'(out_valid), 16'd0);
    chk("a_count2", cw_count, 16'd2);
    chk("a_hi_count2", 16'(hi_cw_count), 16'd2);

    // Back-to-back 0x81, 0xF0.
    in_data = 8'h81; in_valid = 1'b1;
    step();
    chk("b_cw0", 16'(out_code), 16'h0F);
    in_data = 8'hF0;
    step();
    chk("b_cw1", 16'(out_code), 16'h96);
    chk("b_rdy_send1", 16'(in_ready), 16'd1);
    step();
    in_valid = 1'b0;
    chk("b_cw2", 16'(out_code), 16'h00);
    chk("b_valid2", 16'(out_valid), 16'd1);
    step();
    chk("b_cw3", 16'(out_code), 16'hFF);
    chk("b_rdy_send1b", 16'(in_ready), 16'd1);
    step();
    chk("b_idle", 16'(out_valid), 16'd0);
    chk("b_count", cw_count, 16'd6);

    // Stall in SEND0 for 5 cycles.
    in_data = 8'h81; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("c_stall_code", 16'(out_code), 16'h0F);
      chk("c_stall_valid", 16'(out_valid), 16'd1);
      chk("c_stall_rdy", 16'(in_ready), 16'd0);
      chk("c_stall_count", cw_count, 16'd6);
    end
    out_ready = 1'b1;
    step();
    chk("c_cw1", 16'(out_code), 16'h96);
    chk("c_count7", cw_count, 16'd7);
    step();
    chk("c_count8", cw_count, 16'd8);

    // Error injection masks.
    in_data = 8'h00; inj_mask = 8'h08; in_valid = 1'b1;
    step();
    in_valid = 1'b0; inj_mask = 8'hFF;
    chk("d_m08_cw0", 16'(out_code), 16'h08);
    step();
    chk("d_m08_cw1", 16'(out_code), 16'h08);
    step();
    chk("d_idle_hold", 16'(out_code), 16'h08);
    in_data = 8'h00; inj_mask = 8'h06; in_valid = 1'b1;
    step();
    in_valid = 1'b0; inj_mask = 8'h00;
    chk("d_m06_cw0", 16'(out_code), 16'h06);
    step();
    chk("d_m06_cw1", 16'(out_code), 16'h06);
    step();
    chk("d_count", cw_count, 16'd12);

    // All 16 nibbles, streamed back-to-back as bytes {n+1, n}.
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_data = {4'(2*k+1), 4'(2*k)};
      step();
      chk("e_lo_code", 16'(out_code), 16'(tbl[2*k]));
      chk("e_lo_synpar", 16'(syn_par(out_code)), 16'd0);
      step();
      chk("e_hi_code", 16'(out_code), 16'(tbl[2*k+1]));
      chk("e_hi_synpar", 16'(syn_par(out_code)), 16'd0);
      if (k == 7) in_valid = 1'b0;
    end
    step();
    chk("e_count", cw_count, 16'd28);

    // Reset asserted while in SEND1 discards nothing further.
    in_data = 8'h81; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("f_send1_code", 16'(out_code), 16'h96);
    chk("f_count29", cw_count, 16'd29);
    out_ready = 1'b0; rst = 1'b1;
    step();
    chk("f_rst_valid", 16'(out_valid), 16'd0);
    chk("f_rst_count", cw_count, 16'd0);
    chk("f_rst_code", 16'(out_code), 16'h00);
    chk("f_rst_rdy", 16'(in_ready), 16'd0);
    rst = 1'b0; out_ready = 1'b1;
    step();
    chk("f_no_cw", 16'(out_valid), 16'd0);
    chk("f_count0", cw_count, 16'd0);

    // Counter wrap on the 4-bit instance: 16 transfers from zero.
    in_data = 8'h55; in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      step();
      if (i == 14) in_valid = 1'b0;
      if (i == 15) begin
        chk("g_hi_cnt15", 16'(hi_cw_count), 16'd15);
        chk("g_cnt15", cw_count, 16'd15);
      end
      if (i == 16) begin
        chk("g_hi_wrap", 16'(hi_cw_count), 16'd0);
        chk("g_cnt16", cw_count, 16'd16);
        chk("g_idle", 16'(out_valid), 16'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
